// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative unsigned multiply/divide unit (MULTU/DIVU) producing a HI/LO pair.
// It does no arithmetic itself. Each iteration phase issues one operation to an
// external ALU and consumes that ALU's combinational result in the same cycle.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_start         begin operation, sampled only in IDLE
//   i_op            0 = multiply, 1 = divide
//   i_a             multiplicand / dividend
//   i_b             multiplier / divisor
//   o_busy          operation in progress
//   o_done          one-cycle pulse, hi/lo valid
//   o_div_by_zero   divide with b = 0; held until the next accepted start
//   o_hi            product[63:32] / remainder
//   o_lo            product[31:0]  / quotient
//   o_alu_cnt       ALU code: 0000 add, 0001 sub, 0111 unsigned set-less-than
//   o_alu_shamt     ALU shift amount, always 0
//   o_alu_in1       ALU operand 1
//   o_alu_in2       ALU operand 2
//   i_alu_result    ALU result, same cycle
module muldiv_sequencer #(
  parameter int WIDTH       = 32,
  parameter int ITER_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [3:0]       o_alu_cnt,
  output logic [4:0]       o_alu_shamt,
  output logic [WIDTH-1:0] o_alu_in1,
  output logic [WIDTH-1:0] o_alu_in2,
  input  logic [WIDTH-1:0] i_alu_result
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0111;

  // One iteration step spans ITER_CYCLES phases. The whole operation takes
  // WIDTH*ITER_CYCLES busy cycles, which gives WIDTH steps of two phases each.
  localparam int         STEPS     = (WIDTH * ITER_CYCLES) / 2;
  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  typedef enum logic [2:0] {
    IDLE, MUL_ADD, MUL_CMP, DIV_CMP, DIV_SUB, FIN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_tmp;
  logic [5:0]       r_cnt;
  logic             r_ge;
  logic             r_dbz;
  logic [WIDTH-1:0] w_rs;
  logic             w_msb;
  logic             w_last;

  // Divide works on the partial remainder shifted left by one and fed from the
  // dividend's top bit. The bit shifted out of hi is the 33rd remainder bit.
  // Both values depend only on registers, so they stay stable across DIV_CMP
  // and DIV_SUB.
  assign w_rs   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_msb  = r_hi[WIDTH-1];
  assign w_last = (r_cnt == LAST_STEP);

  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_div_by_zero = r_dbz;
  assign o_alu_shamt   = 5'd0;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic plus the ALU request for the current phase. In IDLE and
  // FIN the ALU sees an add of zeros, so the port is quiet between operations.
  always_comb begin
    w_next    = r_state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_alu_cnt = ALU_ADD;
    o_alu_in1 = '0;
    o_alu_in2 = '0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (!i_op)           w_next = MUL_ADD;
          else if (i_b == '0)  w_next = FIN;
          else                 w_next = DIV_CMP;
        end
      end
      MUL_ADD: begin
        o_busy    = 1'b1;
        o_alu_in1 = r_hi;
        o_alu_in2 = r_lo[0] ? r_mcand : '0;
        w_next    = MUL_CMP;
      end
      MUL_CMP: begin
        // The wrapped sum is smaller than hi exactly when the add carried out.
        o_busy    = 1'b1;
        o_alu_cnt = ALU_SLTU;
        o_alu_in1 = r_tmp;
        o_alu_in2 = r_hi;
        w_next    = w_last ? FIN : MUL_ADD;
      end
      DIV_CMP: begin
        o_busy    = 1'b1;
        o_alu_cnt = ALU_SLTU;
        o_alu_in1 = w_rs;
        o_alu_in2 = r_mcand;
        w_next    = DIV_SUB;
      end
      DIV_SUB: begin
        o_busy    = 1'b1;
        o_alu_cnt = ALU_SUB;
        o_alu_in1 = w_rs;
        o_alu_in2 = r_mcand;
        w_next    = w_last ? FIN : DIV_CMP;
      end
      FIN: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath registers. Operands are captured only on an accepted start, so
  // input changes during an operation have no effect. In the divide-by-zero
  // case the result is loaded directly and the machine goes straight to FIN.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_tmp   <= '0;
      r_cnt   <= '0;
      r_ge    <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
            r_mcand <= i_b;
            if (i_op && i_b == '0) begin
              r_hi  <= i_a;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_hi <= '0;
              r_lo <= i_a;
            end
          end
        end
        MUL_ADD: r_tmp <= i_alu_result;
        MUL_CMP: begin
          // Shift the 65-bit {carry, sum, lo} right by one.
          r_hi  <= {i_alu_result[0], r_tmp[WIDTH-1:1]};
          r_lo  <= {r_tmp[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + 6'd1;
        end
        DIV_CMP: r_ge <= w_msb | ~i_alu_result[0];
        DIV_SUB: begin
          // Restoring step: keep the difference only if the divisor fit.
          r_hi  <= r_ge ? i_alu_result : w_rs;
          r_lo  <= {r_lo[WIDTH-2:0], r_ge};
          r_cnt <= r_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
